// File: rtl/uart_cfg_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_cfg_pkg
// Shared definitions for the config-UART frame controller.
//   state_t            FSM state encoding
//   SYNC_BYTE_DEFAULT  default frame start marker
//   chk_ok()           checksum test: (sum + rx_byte) mod 256 == 0
// -----------------------------------------------------------------------------
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_CHK   = 3'd3,
        S_ISSUE = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // A frame is good when the running sum plus the CHK byte wraps to zero.
    function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] rx_byte);
        logic [7:0] total;
        total = sum + rx_byte;
        return (total == 8'h00);
    endfunction

endpackage

// File: rtl/uart_cfg_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_cfg_wr_if
// Register-write request bus between the frame controller and the config
// register file. Valid/ready handshake; addr and data are qualified by valid.
//   wr_valid  write request pending            (master -> slave)
//   wr_ready  register file accepts the write  (slave  -> master)
//   wr_addr   write address, ADDR_W bits       (master -> slave)
//   wr_data   write data, 8*DATA_BYTES bits    (master -> slave)
// -----------------------------------------------------------------------------
interface uart_cfg_wr_if #(
    parameter int ADDR_W     = 8,
    parameter int DATA_BYTES = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*DATA_BYTES-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/uart_cfg_frame_ctrl_timer.sv
// -----------------------------------------------------------------------------
// uart_cfg_timer
// Inter-byte timeout counter. Counts clocks while enabled and not cleared;
// expire is asserted in the cycle the count sits at TIMEOUT_CLKS-1 with no
// clear, and the counter reloads to zero on that same edge.
//   i_Clock  in   system clock
//   i_Reset  in   synchronous reset, active-high
//   clear    in   reload the count to zero (a byte arrived)
//   enable   in   count while high; held at zero while low
//   expire   out  timeout reached this cycle
// -----------------------------------------------------------------------------
module uart_cfg_timer #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS);

    logic [CNT_W-1:0] count_q;

    assign expire = enable && !clear && (count_q == CNT_W'(TIMEOUT_CLKS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            count_q <= '0;
        end else if (clear || !enable || expire) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_cfg_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cfg_frame_ctrl
// Turns the config UART byte stream into register-write transactions.
// Frame: SYNC, ADDR, D[0..DATA_BYTES-1] (D[0] = MSB byte), CHK, where
// (ADDR + all D + CHK) mod 256 == 0. Bad checksum, inter-byte timeout and
// bytes dropped while a write is pending are reported as one-cycle pulses.
//   i_Clock        in   system clock
//   i_Reset        in   synchronous reset, active-high
//   i_Rx_DV        in   one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte      in   received byte
//   wr             master side of the register-write bus
//   o_Err_Chk      out  pulse: checksum mismatch
//   o_Err_Timeout  out  pulse: inter-byte timeout
//   o_Err_Overrun  out  pulse: byte dropped while write pending
//   o_Busy         out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_cfg_frame_ctrl
    import uart_cfg_pkg::*;
#(
    parameter int         ADDR_W       = 8,
    parameter int         DATA_BYTES   = 4,
    parameter int         TIMEOUT_CLKS = 100000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_Rx_DV,
    input  logic [7:0]         i_Rx_Byte,
    uart_cfg_wr_if.master      wr,
    output logic               o_Err_Chk,
    output logic               o_Err_Timeout,
    output logic               o_Err_Overrun,
    output logic               o_Busy
);

    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    if (DATA_BYTES < 1) begin : g_bad_data_bytes
        $error("uart_cfg_frame_ctrl: DATA_BYTES must be >= 1");
    end
    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("uart_cfg_frame_ctrl: TIMEOUT_CLKS must be >= 2");
    end
    if ((ADDR_W < 1) || (ADDR_W > 8)) begin : g_bad_addr_w
        $error("uart_cfg_frame_ctrl: ADDR_W must be in 1..8");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [7:0]          sum_q;
    logic [IDX_W-1:0]    idx_q;
    logic                err_chk_q, err_to_q, err_ovr_q;

    // Decoded controls from the next-state logic.
    logic ld_addr;
    logic ld_data;
    logic chk_fail;
    logic timeout;
    logic overrun;

    logic in_frame;
    logic expire;
    logic last_data;

    assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign last_data = (idx_q == IDX_W'(DATA_BYTES - 1));

    // Any received byte restarts the inter-byte window.
    uart_cfg_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .clear   (i_Rx_DV),
        .enable  (in_frame),
        .expire  (expire)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        ld_addr  = 1'b0;
        ld_data  = 1'b0;
        chk_fail = 1'b0;
        timeout  = 1'b0;
        overrun  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end

            // ADDR may equal SYNC_BYTE: no resync once a frame has started.
            S_ADDR: begin
                if (i_Rx_DV) begin
                    ld_addr = 1'b1;
                    state_d = S_DATA;
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                if (i_Rx_DV) begin
                    ld_data = 1'b1;
                    if (last_data) begin
                        state_d = S_CHK;
                    end
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_CHK: begin
                if (i_Rx_DV) begin
                    if (chk_ok(sum_q, i_Rx_Byte)) begin
                        state_d = S_ISSUE;
                    end else begin
                        chk_fail = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end

            // A byte arriving on the handshake cycle is treated as if the
            // FSM were already idle, so a back-to-back SYNC is not lost.
            S_ISSUE: begin
                if (wr.wr_ready) begin
                    state_d = (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) ? S_ADDR : S_IDLE;
                end else if (i_Rx_DV) begin
                    overrun = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address, data, checksum and byte index only move while a frame is
    // being received, so they stay stable through S_ISSUE.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            addr_q <= '0;
            data_q <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
        end else if (ld_addr) begin
            addr_q <= i_Rx_Byte[ADDR_W-1:0];
            sum_q  <= i_Rx_Byte;
            idx_q  <= '0;
        end else if (ld_data) begin
            data_q <= (data_q << 8) | DATA_W'(i_Rx_Byte);
            sum_q  <= sum_q + i_Rx_Byte;
            idx_q  <= last_data ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            err_chk_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            err_chk_q <= chk_fail;
            err_to_q  <= timeout;
            err_ovr_q <= overrun;
        end
    end

    assign wr.wr_valid   = (state_q == S_ISSUE);
    assign wr.wr_addr    = addr_q;
    assign wr.wr_data    = data_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Timeout = err_to_q;
    assign o_Err_Overrun = err_ovr_q;
    assign o_Busy        = (state_q != S_IDLE);

endmodule
